// File: rtl/inst_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_if
//   Instruction-memory read bus between the fetch unit (master) and the
//   instruction memory (slave). No address pipelining: one access at a time.
//
//   Handshake: the master holds mem_addr stable for the whole access. The
//   memory signals its progress on mem_r_status (00 idle, 01 busy,
//   10 data valid, 11 illegal); mem_r_data is meaningful only in the cycle
//   where mem_r_status==2'b10, and the response is consumed on that posedge.
//   mem_abort (the memory's stall input) kills any access in progress and
//   forces the status back to 00 while it is high.
//
//   Signals
//     mem_addr      master->slave  32  request address
//     mem_abort     master->slave   1  abort / stall
//     mem_r_data    slave->master  32  read data
//     mem_r_status  slave->master   2  access status
// -----------------------------------------------------------------------------
interface inst_fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_abort;
  logic [31:0] mem_r_data;
  logic [1:0]  mem_r_status;

  modport master (
    output mem_addr,
    output mem_abort,
    input  mem_r_data,
    input  mem_r_status
  );

  modport slave (
    input  mem_addr,
    input  mem_abort,
    output mem_r_data,
    output mem_r_status
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Requesting end of the instruction-memory read bus. Holds the fetch PC,
//   presents it as a stable request address, collects each response and
//   queues {pc, inst} pairs in a small FIFO that feeds decode.
//
//   Decode handshake: out_valid/out_ready. The head entry is transferred on a
//   posedge where out_valid & out_ready; out_inst/out_pc read 0 when empty.
//
//   Redirects restart fetch at redirect_pc, flush the FIFO and abort the
//   in-flight memory access for that cycle.
//
//   Ports
//     clk             in   1   clock, all state on posedge
//     rst_n           in   1   asynchronous active-low reset
//     redirect_valid  in   1   one-cycle pulse: restart fetch at redirect_pc
//     redirect_pc     in   32  new fetch address, [1:0] ignored
//     out_valid       out  1   FIFO head valid
//     out_ready       in   1   decode accepts head
//     out_inst        out  32  head instruction word
//     out_pc          out  32  head instruction address
//     mem             if       inst_fetch_unit_if.master (memory bus)
//     mem_err         out  1   sticky: illegal status (2'b11) seen
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_inst,
  output logic [31:0]               out_pc,
  inst_fetch_unit_if.master         mem,
  output logic                      mem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  localparam logic [1:0] ST_VALID   = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   pc_q,     pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          err_q,    err_d;

  // FIFO payload; contents are don't-care while count_q==0, so no reset.
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  // The low address bits of a redirect target are dropped on purpose.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic resp_valid;
  logic resp_illegal;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign resp_valid   = (mem.mem_r_status == ST_VALID);
  assign resp_illegal = (mem.mem_r_status == ST_ILLEGAL);
  assign fifo_full    = (count_q == FULL_CNT);
  assign fifo_empty   = (count_q == '0);

  // A redirect wins over everything: the response is dropped and the pop is
  // ignored because the whole queue is about to be flushed. The full term is
  // defensive; abort keeps the memory idle while full, so it never fires.
  assign push = resp_valid & ~redirect_valid & ~fifo_full;
  assign pop  = ~fifo_empty & out_ready & ~redirect_valid;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | resp_illegal;

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        // 32-bit wrap: 32'hFFFF_FFFC advances to 0.
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= mem.mem_r_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = ~fifo_empty;
  assign out_pc    = fifo_empty ? 32'h0 : pc_mem[rd_ptr_q];
  assign out_inst  = fifo_empty ? 32'h0 : inst_mem[rd_ptr_q];

  // The address only moves on push or redirect, so it is stable for an access.
  assign mem.mem_addr = pc_q;

  // Abort holds the memory idle during reset, kills the in-flight access on a
  // redirect, and stops new accesses while there is no room for the result.
  assign mem.mem_abort = ~rst_n | redirect_valid | fifo_full;

  assign mem_err = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Directed bench for inst_fetch_unit with a behavioural instruction memory
//   (LAT=2: 00 -> 01 x3 -> 10 -> 00 while not aborted). Per-cycle vectors hold
//   inputs and hand-computed expected outputs; a hand-written sequence covers
//   asynchronous reset mid-access and the restart after it.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam int          LAT      = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        mem_err;

  always #5 clk = ~clk;

  inst_fetch_unit_if mem_if ();

  inst_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .mem            (mem_if),
    .mem_err        (mem_err)
  );

  // ---------------------------------------------------------------------------
  // Memory model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  logic [1:0] st_q = 2'b00;
  int         cnt_q = 0;
  logic       inj_err = 1'b0;

  always @(posedge clk) begin
    if (mem_if.mem_abort) begin
      st_q  <= 2'b00;
      cnt_q <= 0;
    end else begin
      case (st_q)
        2'b00: begin st_q <= 2'b01; cnt_q <= 0; end
        2'b01: begin
          if (cnt_q == LAT) st_q <= 2'b10;
          else cnt_q <= cnt_q + 1;
        end
        default: st_q <= 2'b00;
      endcase
    end
  end

  assign mem_if.mem_r_status = inj_err ? 2'b11 : st_q;
  assign mem_if.mem_r_data   = (st_q == 2'b10) ? img(mem_if.mem_addr) : 32'h0;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rdr;
    logic [31:0] rpc;
    bit          inj;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] ea;
    bit          eab;
    bit          eerr;
  } vec_t;

  vec_t vec_q[$];

  function automatic void add(input int n, input bit rst, input bit rdy, input bit rdr,
                              input logic [31:0] rpc, input bit inj, input bit ev,
                              input logic [31:0] epc, input logic [31:0] ea,
                              input bit eab, input bit eerr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc; v.inj = inj;
    v.ev = ev; v.epc = epc; v.ea = ea; v.eab = eab; v.eerr = eerr;
    for (int k = 0; k < n; k++) vec_q.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin
    // Args: n, rst_n, ready, redirect, redirect_pc, inj_err,
    //       exp_valid, exp_pc, exp_addr, exp_abort, exp_err
    // 1. Streaming with out_ready=1: one instruction every 5 cycles.
    add(1, 0, 1, 0, 0, 0, 0, 32'h0,   32'h100, 1, 0);
    add(5, 1, 1, 0, 0, 0, 0, 32'h0,   32'h100, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 32'h100, 32'h104, 0, 0);
    add(4, 1, 1, 0, 0, 0, 0, 32'h0,   32'h104, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 32'h104, 32'h108, 0, 0);
    add(4, 1, 1, 0, 0, 0, 0, 32'h0,   32'h108, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 32'h108, 32'h10C, 0, 0);
    // 2. Back-pressure: FIFO fills, abort holds memory idle, then drains.
    add(1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h100, 1, 0);
    add(5, 1, 0, 0, 0, 0, 0, 32'h0,   32'h100, 0, 0);
    add(5, 1, 0, 0, 0, 0, 1, 32'h100, 32'h104, 0, 0);
    add(3, 1, 0, 0, 0, 0, 1, 32'h100, 32'h108, 1, 0);
    add(1, 1, 1, 0, 0, 0, 1, 32'h100, 32'h108, 1, 0);
    add(1, 1, 1, 0, 0, 0, 1, 32'h104, 32'h108, 0, 0);
    add(4, 1, 1, 0, 0, 0, 0, 32'h0,   32'h108, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 32'h108, 32'h10C, 0, 0);
    // 3. Redirect to 0x203 while pc 104 is busy, with pc 100 still queued.
    add(1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h100, 1, 0);
    add(5, 1, 0, 0, 0, 0, 0, 32'h0,   32'h100, 0, 0);
    add(2, 1, 0, 0, 0, 0, 1, 32'h100, 32'h104, 0, 0);
    add(1, 1, 0, 1, 32'h203, 0, 1, 32'h100, 32'h104, 1, 0);
    add(5, 1, 0, 0, 0, 0, 0, 32'h0,   32'h200, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 32'h200, 32'h204, 0, 0);
    // 4. Redirect on the data-valid edge, then a back-to-back redirect to the
    //    top of the address space.
    add(3, 1, 1, 0, 0, 0, 0, 32'h0,   32'h204, 0, 0);
    add(1, 1, 1, 1, 32'h400, 0, 0, 32'h0, 32'h204, 1, 0);
    add(1, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h400, 1, 0);
    add(5, 1, 1, 0, 0, 0, 0, 32'h0,   32'hFFFF_FFFC, 0, 0);
    // 5. Address wrap and an illegal status replacing a response.
    add(1, 1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0);
    add(1, 1, 1, 0, 0, 1, 0, 32'h0,   32'h0,   0, 0);
    add(5, 1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 1);
    add(1, 1, 0, 0, 0, 0, 1, 32'h0,   32'h4,   0, 1);

    repeat (3) @(posedge clk);

    for (int i = 0; i < vec_q.size(); i++) begin
      @(negedge clk);
      rst_n          = vec_q[i].rst;
      out_ready      = vec_q[i].rdy;
      redirect_valid = vec_q[i].rdr;
      redirect_pc    = vec_q[i].rpc;
      inj_err        = vec_q[i].inj;
      #1;
      check($sformatf("row%0d out_valid", i), {31'h0, out_valid}, {31'h0, vec_q[i].ev});
      check($sformatf("row%0d out_pc", i), out_pc, vec_q[i].epc);
      check($sformatf("row%0d out_inst", i), out_inst,
            vec_q[i].ev ? img(vec_q[i].epc) : 32'h0);
      check($sformatf("row%0d mem_addr", i), mem_if.mem_addr, vec_q[i].ea);
      check($sformatf("row%0d mem_abort", i), {31'h0, mem_if.mem_abort}, {31'h0, vec_q[i].eab});
      check($sformatf("row%0d mem_err", i), {31'h0, mem_err}, {31'h0, vec_q[i].eerr});
    end

    // 6. Asynchronous reset mid-access with one entry queued.
    @(negedge clk);
    redirect_valid = 1'b0;
    inj_err        = 1'b0;
    out_ready      = 1'b0;
    #1;
    check("pre_reset out_valid", {31'h0, out_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst out_valid", {31'h0, out_valid}, 32'h0);
    check("async_rst mem_abort", {31'h0, mem_if.mem_abort}, 32'h1);
    check("async_rst out_pc", out_pc, 32'h0);
    check("async_rst mem_addr", mem_if.mem_addr, RESET_PC);
    check("async_rst mem_err", {31'h0, mem_err}, 32'h0);

    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check($sformatf("restart out_pc %0d", c), out_pc, e);
        check($sformatf("restart out_inst %0d", c), out_inst, img(e));
      end
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL restart timeout: %0d entries not seen, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
